template_match_stream: RTL and testbench

- Parametrised, fully streaming successor to the fixed 4000-bit linebuffer → sad → linecounter chain.
- Accepts a binary image one pixel per cycle in raster order and holds a TPL_W x TPL_H sliding window in internal line buffers.
- Each cycle it computes the SAD of the window against a runtime-loadable template, as the popcount of the bitwise XOR.
- Reports each SAD with its window coordinates, flags threshold hits, and tracks the frame-wide best (minimum-SAD) match.

---
 rtl/template_match_stream.sv | 230 +++++++++++++++++++++++
 tb/tb_template_match_stream.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/template_match_stream.sv
// Streaming binary template matcher: sliding-window SAD (popcount of XOR) with threshold hits and best-match tracking.
// Latency: match_valid two cycles after the edge that accepts the window's bottom-right pixel; done two cycles after the last result.
// Backpressure: none; pix_valid gaps become pipeline bubbles, results are never reordered or dropped.
module template_match_stream #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 48,
    parameter int TPL_W = 8,
    parameter int TPL_H = 8,
    parameter int SAD_W = 7,
    parameter int XW    = 6,
    parameter int YW    = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tpl_load,
    input  logic [TPL_W-1:0] tpl_row,
    input  logic             frame_start,
    input  logic             pix_valid,
    input  logic             pix_d,
    input  logic [SAD_W-1:0] threshold,
    output logic             match_valid,
    output logic [SAD_W-1:0] match_sad,
    output logic [XW-1:0]    match_x,
    output logic [YW-1:0]    match_y,
    output logic             hit,
    output logic             busy,
    output logic             done,
    output logic [SAD_W-1:0] best_sad,
    output logic [XW-1:0]    best_x,
    output logic [YW-1:0]    best_y
);
    localparam int NPIX = TPL_W * TPL_H;
    localparam int PW   = $clog2(TPL_H);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t            state, state_nxt;
    logic [XW-1:0]     x, cur_x;
    logic [YW-1:0]     y, cur_y;
    logic              start, accept, last_pix, win_full;
    logic [1:0]        epoch, epoch_nxt;
    logic [PW-1:0]     tpl_ptr;
    logic [TPL_W-1:0]  tpl [TPL_H];
    logic [IMG_W-1:0]  lb  [TPL_H-1];
    logic [TPL_W-1:0]  win [TPL_H];
    logic [TPL_H-1:0]  col;
    logic [NPIX-1:0]   win_xor;
    logic              w_vld, w_last, s1_vld, s1_last, s2_last, upd_last;
    logic [1:0]        w_ep, s1_ep, s2_ep;
    logic [XW-1:0]     w_x, s1_x;
    logic [YW-1:0]     w_y, s1_y;
    logic [NPIX-1:0]   s1_xor;
    logic [SAD_W-1:0]  pop;

    // A qualified frame_start restarts the frame from any state; that pixel is (0,0).
    assign start     = pix_valid & frame_start;
    assign accept    = start | (pix_valid & (state == RUN));
    assign cur_x     = start ? '0 : x;
    assign cur_y     = start ? '0 : y;
    assign last_pix  = (cur_x == XW'(IMG_W-1)) && (cur_y == YW'(IMG_H-1));
    assign win_full  = (cur_x >= XW'(TPL_W-1)) && (cur_y >= YW'(TPL_H-1));
    // The epoch tags results so that leftovers of an aborted frame cannot touch best_*.
    assign epoch_nxt = start ? epoch + 2'd1 : epoch;
    assign busy      = (state != IDLE);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state: run until the last pixel, then drain until the final result has updated best_*
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (accept && last_pix) state_nxt = DRAIN;
            DRAIN:   if (start) state_nxt = RUN;
                     else if (upd_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Raster position of the next expected pixel, plus the frame epoch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x     <= '0;
            y     <= '0;
            epoch <= '0;
        end else begin
            epoch <= epoch_nxt;
            if (accept) begin
                if (last_pix) begin
                    x <= '0;
                    y <= '0;
                end else if (cur_x == XW'(IMG_W-1)) begin
                    x <= '0;
                    y <= cur_y + YW'(1);
                end else begin
                    x <= cur_x + XW'(1);
                    y <= cur_y;
                end
            end
        end
    end

    // Template rows are written only while idle; the row pointer rewinds on each new frame
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tpl_ptr <= '0;
            for (int r = 0; r < TPL_H; r++) tpl[r] <= '0;
        end else if (start) begin
            tpl_ptr <= '0;
        end else if (tpl_load && !busy) begin
            tpl[tpl_ptr] <= tpl_row;
            tpl_ptr      <= (tpl_ptr == PW'(TPL_H-1)) ? '0 : tpl_ptr + PW'(1);
        end
    end

    // New window column: line-buffer taps on top (oldest row first), the live pixel at the bottom
    always_comb begin
        col          = '0;
        col[TPL_H-1] = pix_d;
        for (int r = 0; r < TPL_H-1; r++) col[r] = lb[TPL_H-2-r][cur_x];
    end

    // Line buffers cascade row by row; the window shifts left so bit TPL_W-1 holds the newest column
    always_ff @(posedge clk) begin
        if (accept) begin
            lb[0][cur_x] <= pix_d;
            for (int k = 1; k < TPL_H-1; k++) lb[k][cur_x] <= lb[k-1][cur_x];
            for (int r = 0; r < TPL_H; r++) win[r] <= {col[r], win[r][TPL_W-1:1]};
        end
    end

    // Window valid/coordinate tags, aligned with the freshly shifted window
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_vld  <= 1'b0;
            w_last <= 1'b0;
            w_ep   <= '0;
            w_x    <= '0;
            w_y    <= '0;
        end else begin
            w_vld  <= accept & win_full;
            w_last <= accept & last_pix;
            w_ep   <= epoch_nxt;
            w_x    <= cur_x - XW'(TPL_W-1);
            w_y    <= cur_y - YW'(TPL_H-1);
        end
    end

    // Per-pixel mismatch map of window against template
    always_comb begin
        win_xor = '0;
        for (int r = 0; r < TPL_H; r++) win_xor[r*TPL_W +: TPL_W] = win[r] ^ tpl[r];
    end

    // Stage 1: mismatch map and coordinates
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_vld  <= 1'b0;
            s1_last <= 1'b0;
            s1_ep   <= '0;
            s1_x    <= '0;
            s1_y    <= '0;
            s1_xor  <= '0;
        end else begin
            s1_vld  <= w_vld;
            s1_last <= w_vld & w_last;
            s1_ep   <= w_ep;
            s1_x    <= w_x;
            s1_y    <= w_y;
            s1_xor  <= win_xor;
        end
    end

    // Popcount of the mismatch map
    always_comb begin
        pop = '0;
        for (int i = 0; i < NPIX; i++) pop = pop + SAD_W'(s1_xor[i]);
    end

    // Stage 2: SAD result, hit against the threshold presented now
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            match_valid <= 1'b0;
            match_sad   <= '0;
            match_x     <= '0;
            match_y     <= '0;
            hit         <= 1'b0;
            s2_last     <= 1'b0;
            s2_ep       <= '0;
        end else begin
            match_valid <= s1_vld;
            match_sad   <= pop;
            match_x     <= s1_x;
            match_y     <= s1_y;
            hit         <= s1_vld && (pop <= threshold);
            s2_last     <= s1_last;
            s2_ep       <= s1_ep;
        end
    end

    // Best tracking: strict less-than keeps the earliest window on ties; done follows the final update
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            best_sad <= '1;
            best_x   <= '0;
            best_y   <= '0;
            upd_last <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= upd_last & ~start;
            if (start) begin
                best_sad <= '1;
                best_x   <= '0;
                best_y   <= '0;
                upd_last <= 1'b0;
            end else begin
                upd_last <= match_valid & s2_last & (s2_ep == epoch);
                if (match_valid && (s2_ep == epoch) && (match_sad < best_sad)) begin
                    best_sad <= match_sad;
                    best_x   <= match_x;
                    best_y   <= match_y;
                end
            end
        end
    end
endmodule

// File: tb/tb_template_match_stream.sv
// Bench for template_match_stream: random and directed frames against a window-level SAD reference model.
// Latency: checks results two cycles after the completing pixel and done two cycles after the last result.
// Backpressure: none in the design; the bench inserts pix_valid gaps and verifies results are unaffected.
module tb_template_match_stream;
    localparam int IMG_W = 8;
    localparam int IMG_H = 6;
    localparam int TPL_W = 3;
    localparam int TPL_H = 3;
    localparam int SAD_W = 4;
    localparam int XW    = 3;
    localparam int YW    = 3;
    localparam int SAD_MAX = (1 << SAD_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             tpl_load = 1'b0;
    logic [TPL_W-1:0] tpl_row = '0;
    logic             frame_start = 1'b0;
    logic             pix_valid = 1'b0;
    logic             pix_d = 1'b0;
    logic [SAD_W-1:0] threshold = '0;
    logic             match_valid, hit, busy, done;
    logic [SAD_W-1:0] match_sad, best_sad;
    logic [XW-1:0]    match_x, best_x;
    logic [YW-1:0]    match_y, best_y;

    template_match_stream #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .TPL_W(TPL_W), .TPL_H(TPL_H),
        .SAD_W(SAD_W), .XW(XW), .YW(YW)
    ) dut (
        .clk(clk), .rst(rst), .tpl_load(tpl_load), .tpl_row(tpl_row),
        .frame_start(frame_start), .pix_valid(pix_valid), .pix_d(pix_d),
        .threshold(threshold), .match_valid(match_valid), .match_sad(match_sad),
        .match_x(match_x), .match_y(match_y), .hit(hit), .busy(busy), .done(done),
        .best_sad(best_sad), .best_x(best_x), .best_y(best_y)
    );

    always #5 clk = ~clk;

    typedef struct { int sad; int x; int y; } res_t;

    res_t             exp_q[$];
    int               lat_q[$];
    res_t             mon_e;
    bit               img [IMG_H][IMG_W];
    logic [TPL_W-1:0] tpl_m [TPL_H];
    int best_sad_m, best_x_m, best_y_m, thr_i;
    int n_chk = 0, n_err = 0;
    int cyc = 0, done_cnt = 0, done_cyc = 0, last_mv = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: every full window in raster order, SAD = count of differing pixels
    task automatic build_model();
        int s;
        exp_q.delete();
        lat_q.delete();
        best_sad_m = SAD_MAX;
        best_x_m = 0;
        best_y_m = 0;
        for (int wy = 0; wy <= IMG_H - TPL_H; wy++)
            for (int wx = 0; wx <= IMG_W - TPL_W; wx++) begin
                s = 0;
                for (int r = 0; r < TPL_H; r++)
                    for (int c = 0; c < TPL_W; c++)
                        if (img[wy+r][wx+c] != tpl_m[r][c]) s++;
                exp_q.push_back('{s, wx, wy});
                if (s < best_sad_m) begin
                    best_sad_m = s;
                    best_x_m = wx;
                    best_y_m = wy;
                end
            end
    endtask

    // Result and done monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (match_valid) begin
            if (exp_q.size() == 0) begin
                check("extra_result", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("sad", match_sad, mon_e.sad);
                check("x", match_x, mon_e.x);
                check("y", match_y, mon_e.y);
                check("hit", hit, (mon_e.sad <= thr_i) ? 1 : 0);
                if (lat_q.size() == 0) check("latency_missing", 1, 0);
                else check("latency", cyc, lat_q.pop_front() + 2);
            end
            last_mv = cyc;
        end else begin
            check("hit_idle", hit, 0);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            check("best_sad", best_sad, best_sad_m);
            check("best_x", best_x, best_x_m);
            check("best_y", best_y, best_y_m);
        end
    end

    task automatic load_tpl();
        for (int r = 0; r < TPL_H; r++) begin
            tpl_load = 1'b1;
            tpl_row = tpl_m[r];
            @(posedge clk); #1;
        end
        tpl_load = 1'b0;
    endtask

    // gapm: 0 gapless, 1 alternating 1-0-1, 2 random gaps; junk drives tpl_load while busy
    task automatic drive_pixels(input int gapm, input bit junk, input int npix);
        int g, px, py;
        for (int i = 0; i < npix; i++) begin
            px = i % IMG_W;
            py = i / IMG_W;
            if (i != 0) begin
                g = (gapm == 1) ? 1 : (gapm == 2) ? int'($urandom_range(0, 2)) : 0;
                if (g > 0) begin
                    pix_valid = 1'b0;
                    frame_start = 1'b0;
                    tpl_load = 1'b0;
                    repeat (g) @(posedge clk);
                    #1;
                end
            end
            pix_valid = 1'b1;
            frame_start = (i == 0);
            pix_d = img[py][px];
            tpl_load = junk && (i != 0);
            tpl_row = TPL_W'($urandom);
            if (px >= TPL_W - 1 && py >= TPL_H - 1) lat_q.push_back(cyc + 1);
            @(posedge clk); #1;
        end
        pix_valid = 1'b0;
        frame_start = 1'b0;
        tpl_load = 1'b0;
    endtask

    task automatic run_frame(input int gapm, input bit junk);
        int t, d0;
        build_model();
        d0 = done_cnt;
        drive_pixels(gapm, junk, IMG_W * IMG_H);
        t = 0;
        while (done_cnt == d0 && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        repeat (4) @(posedge clk);
        #1;
        check("done_count", done_cnt - d0, 1);
        check("done_latency", done_cyc, last_mv + 2);
        check("results_left", exp_q.size(), 0);
        check("busy_after", busy, 0);
    endtask

    task automatic fill_img(input int mode);
        for (int py = 0; py < IMG_H; py++)
            for (int px = 0; px < IMG_W; px++)
                case (mode)
                    0: img[py][px] = 1'b0;
                    1: img[py][px] = 1'b1;
                    2: img[py][px] = (px >= 4 && px <= 6 && py >= 2 && py <= 4);
                    default: img[py][px] = 1'($urandom);
                endcase
    endtask

    task automatic set_tpl(input int mode);
        for (int r = 0; r < TPL_H; r++)
            tpl_m[r] = (mode == 0) ? '0 : (mode == 1) ? '1 : TPL_W'($urandom);
    endtask

    task automatic set_thr(input int v);
        thr_i = v;
        threshold = SAD_W'(v);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int d0;
        set_thr(0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_match_valid", match_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_best_sad", best_sad, SAD_MAX);
        check("rst_best_x", best_x, 0);
        check("rst_best_y", best_y, 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // All-ones template on all-ones image: every SAD 0, every window a hit
        set_tpl(1); load_tpl(); fill_img(1); set_thr(0);
        run_frame(0, 1'b0);

        // All-zero template on all-ones image: SAD 9 everywhere, tie keeps (0,0)
        set_tpl(0); load_tpl(); fill_img(1); set_thr(8);
        run_frame(0, 1'b0);

        // Ones block at cols 4..6 rows 2..4: unique zero-SAD window at (4,2)
        set_tpl(1); load_tpl(); fill_img(2); set_thr(0);
        run_frame(0, 1'b0);
        check("block_best", best_sad * 64 + best_x * 8 + best_y, 0 * 64 + 4 * 8 + 2);
        // Same frame with alternating valid gaps
        run_frame(1, 1'b0);

        // Random frames, random gaps, template writes while busy must be ignored
        for (int k = 0; k < 4; k++) begin
            set_tpl(2); load_tpl(); fill_img(3); set_thr($urandom_range(0, 9));
            run_frame(2, 1'b1);
            fill_img(3);
            run_frame(k % 3, 1'b1);
        end

        // Reset mid-frame: immediate reset values, no done, template cleared
        set_tpl(2); load_tpl(); fill_img(3); set_thr(4);
        build_model();
        d0 = done_cnt;
        drive_pixels(0, 1'b0, 20);
        #2 rst = 1'b0;
        #1;
        check("abort_match_valid", match_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_hit", hit, 0);
        check("abort_best_sad", best_sad, SAD_MAX);
        check("abort_best_xy", best_x + best_y, 0);
        exp_q.delete();
        lat_q.delete();
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("abort_no_done", done_cnt - d0, 0);
        set_tpl(0); fill_img(3); set_thr(5);
        run_frame(0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
